trng_collect: RTL and testbench

Responder-side engine that produces the `trng_out` value consumed by the key-derivation flow (sha3 digest input, matmlt vector, gjelim success check). It samples a raw entropy bit from a ring-oscillator sampler and removes bias with a Von Neumann corrector. It shifts the corrected bits into an NBITS-wide word and delivers that word through the same req/res handshake the top-level sequencer already uses for sha3, matmlt, ro_pair_puf and gjelim.

---
 rtl/trng_collect.sv | 156 +++++++++++++++
 tb/tb_trng_collect.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collect.sv
// trng_collect: ring-oscillator entropy collector with a Von Neumann corrector behind the req/res handshake.
// Define TRNG_HEALTH_EN to build the repetition-count health test; otherwise fail is held at 0.
module trng_collect #(
    parameter int NBITS      = 128,
    parameter int DIV        = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             raw_bit,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             req_busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NBITS-1:0] rnd_out,
    output logic             fail
);
    // state     | meaning
    // S_IDLE    | waiting for a request; previous result and fail held
    // S_COLLECT | decimated sampling, debiasing, shifting bits into rnd_out
    // S_DONE    | result offered until res_ready

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic [DW-1:0] div_cnt;
    logic          phase;
    logic          a_bit;
    logic [CW-1:0] bit_cnt;
    logic          strobe;
    logic          emit;
    logic          last_bit;
    logic          trip;

    generate
        if (NBITS < 2)      begin : g_bad_nbits $error("NBITS must be >= 2");      end
        if (DIV < 1)        begin : g_bad_div   $error("DIV must be >= 1");        end
        if (RCT_CUTOFF < 2) begin : g_bad_rct   $error("RCT_CUTOFF must be >= 2"); end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
        end
    end

    assign strobe   = (state == S_COLLECT) && (div_cnt == DW'(DIV - 1));
    assign emit     = strobe && phase && (a_bit != sync2);
    assign last_bit = emit && (bit_cnt == CW'(NBITS - 1));

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    logic [RW-1:0] rct_cnt;
    logic [RW-1:0] rct_next;
    logic          prev_s;

    // A zero count marks the first strobe of a collection, which has no predecessor.
    always_comb begin
        rct_next = rct_cnt;
        if ((rct_cnt == '0) || (prev_s != sync2)) begin
            rct_next = RW'(1);
        end else if (rct_cnt != RW'(RCT_CUTOFF)) begin
            rct_next = rct_cnt + RW'(1);
        end
    end

    assign trip = strobe && (rct_next == RW'(RCT_CUTOFF));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rct_cnt <= '0;
            prev_s  <= 1'b0;
        end else if ((state == S_IDLE) && req_valid) begin
            rct_cnt <= '0;
        end else if (strobe) begin
            rct_cnt <= rct_next;
            prev_s  <= sync2;
        end
    end
`else
    assign trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            phase   <= 1'b0;
            a_bit   <= 1'b0;
            bit_cnt <= '0;
            rnd_out <= '0;
            fail    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state   <= S_COLLECT;
                        div_cnt <= '0;
                        phase   <= 1'b0;
                        bit_cnt <= '0;
                        rnd_out <= '0;
                        fail    <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    div_cnt <= strobe ? '0 : div_cnt + DW'(1);
                    if (strobe) begin
                        phase <= ~phase;
                        if (!phase) begin
                            a_bit <= sync2;
                        end
                    end
                    if (emit) begin
                        rnd_out <= {rnd_out[NBITS-2:0], a_bit};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                    // A health trip overrides a word that completes on the same strobe.
                    if (trip) begin
                        state   <= S_DONE;
                        fail    <= 1'b1;
                        rnd_out <= '0;
                    end else if (last_bit) begin
                        state <= S_DONE;
                        fail  <= 1'b0;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign req_busy  = (state == S_COLLECT) || (state == S_DONE);
    assign res_valid = (state == S_DONE);

endmodule

// File: tb/tb_trng_collect.sv
// Directed bench for trng_collect: one DIV=1/NBITS=128 instance and one DIV=3/NBITS=8 instance.
module tb_trng_collect;

    localparam logic [127:0] ALT_WORD  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
    localparam logic [127:0] ONES_WORD = {128{1'b1}};

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         raw_bit = 1'b0;
    logic         req_valid = 1'b0;
    logic         res_ready = 1'b0;

    logic         req_ready_a, req_busy_a, res_valid_a, fail_a;
    logic [127:0] rnd_out_a;
    logic         req_ready_b, req_busy_b, res_valid_b, fail_b;
    logic [7:0]   rnd_out_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trng_collect #(.NBITS(128), .DIV(1), .RCT_CUTOFF(32)) dut_a (
        .clk(clk), .rstn(rstn), .raw_bit(raw_bit), .req_valid(req_valid),
        .req_ready(req_ready_a), .req_busy(req_busy_a), .res_valid(res_valid_a),
        .res_ready(res_ready), .rnd_out(rnd_out_a), .fail(fail_a)
    );

    trng_collect #(.NBITS(8), .DIV(3), .RCT_CUTOFF(32)) dut_b (
        .clk(clk), .rstn(rstn), .raw_bit(raw_bit), .req_valid(req_valid),
        .req_ready(req_ready_b), .req_busy(req_busy_b), .res_valid(res_valid_b),
        .res_ready(res_ready), .rnd_out(rnd_out_b), .fail(fail_b)
    );

    // Sample sequence per strobe: 0 = (1,0),(0,1) pairs, 1 = (1,1),(1,0) pairs, 2 = stuck at 0.
    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return ((k % 4) == 0 || (k % 4) == 3) ? 1'b1 : 1'b0;
            1:       return ((k % 4) != 3) ? 1'b1 : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // n = edge index relative to accept edge, plus one; strobe j (1-based) reads raw at n = j*div-1.
    function automatic int pidx(input int n, input int div);
        int t;
        t = (n + 1) / div - 1;
        return (t < 0) ? 0 : t;
    endfunction

    // Drives one request and the raw stream; returns the cycle res_valid was first seen (0 = never).
    task automatic collect(input int which, input int div, input int mode, input int max_cyc,
                           input int hold_req, input int rr_at, input int abort_at,
                           output int lat, output int busy_first, output int busy_cnt);
        logic rv, bz;
        lat = 0;
        busy_first = 0;
        busy_cnt = 0;
        @(negedge clk);
        raw_bit = pat(mode, pidx(0, div));
        req_valid = 1'b0;
        @(negedge clk);
        raw_bit = pat(mode, pidx(1, div));
        req_valid = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            req_valid = (c <= hold_req) ? 1'b1 : 1'b0;
            res_ready = (c == rr_at) ? 1'b1 : 1'b0;
            if (abort_at != 0 && c == abort_at) begin
                rstn = 1'b0;
                res_ready = 1'b0;
                return;
            end
            rv = which ? res_valid_b : res_valid_a;
            bz = which ? req_busy_b : req_busy_a;
            if (bz && busy_first == 0) busy_first = c;
            if (bz) busy_cnt++;
            if (rv) begin
                lat = c;
                res_ready = 1'b0;
                return;
            end
            raw_bit = pat(mode, pidx(c + 1, div));
        end
        res_ready = 1'b0;
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready_a); end
        vectors++;
        if (req_busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_req_busy: got %b want 0", req_busy_a); end
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (res_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid: got %b want 0", res_valid_a); end
        vectors++;
        if (rnd_out_a !== 128'h0) begin miscompares++; $display("FAIL reset_rnd_out: got %h want 0", rnd_out_a); end
        vectors++;
        if (fail_a !== 1'b0) begin miscompares++; $display("FAIL reset_fail: got %b want 0", fail_a); end
        vectors++;
        if (req_ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", req_ready_a); end
    endtask

    task automatic test_alternating();
        int lat, bf, bc;
        collect(0, 1, 0, 400, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 257) begin miscompares++; $display("FAIL alt_latency: got %0d want 257", lat); end
        vectors++;
        if (rnd_out_a !== ALT_WORD) begin miscompares++; $display("FAIL alt_word: got %h want %h", rnd_out_a, ALT_WORD); end
        vectors++;
        if (fail_a !== 1'b0) begin miscompares++; $display("FAIL alt_fail: got %b want 0", fail_a); end
        release_result();
    endtask

    task automatic test_discard();
        int lat, bf, bc;
        collect(0, 1, 1, 700, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 513) begin miscompares++; $display("FAIL discard_latency: got %0d want 513", lat); end
        vectors++;
        if (rnd_out_a !== ONES_WORD) begin miscompares++; $display("FAIL discard_word: got %h want all ones", rnd_out_a); end
        vectors++;
        if (fail_a !== 1'b0) begin miscompares++; $display("FAIL discard_fail: got %b want 0", fail_a); end
        release_result();
    endtask

    task automatic test_stuck();
        int lat, bf, bc;
`ifdef TRNG_HEALTH_EN
        collect(0, 1, 2, 80, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 33) begin miscompares++; $display("FAIL stuck_latency: got %0d want 33", lat); end
        vectors++;
        if (fail_a !== 1'b1) begin miscompares++; $display("FAIL stuck_fail: got %b want 1", fail_a); end
        vectors++;
        if (rnd_out_a !== 128'h0) begin miscompares++; $display("FAIL stuck_word: got %h want 0", rnd_out_a); end
        release_result();
        vectors++;
        if (req_ready_a !== 1'b1) begin miscompares++; $display("FAIL stuck_back_idle: got %b want 1", req_ready_a); end
`else
        collect(0, 1, 2, 100, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 0) begin miscompares++; $display("FAIL stuck_no_done: got %0d want 0", lat); end
        vectors++;
        if (bc !== 100) begin miscompares++; $display("FAIL stuck_busy_cycles: got %0d want 100", bc); end
        vectors++;
        if (fail_a !== 1'b0) begin miscompares++; $display("FAIL stuck_fail: got %b want 0", fail_a); end
        pulse_reset();
`endif
    endtask

    task automatic test_handshake();
        int lat, bf, bc, idle_busy;
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (req_ready_a !== 1'b1 || res_valid_a !== 1'b0 || req_busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL hs_idle_res_ready: got ready=%b valid=%b busy=%b want 1 0 0", req_ready_a, res_valid_a, req_busy_a);
        end
        collect(0, 1, 0, 400, 2, 50, 0, lat, bf, bc);
        vectors++;
        if (lat !== 257) begin miscompares++; $display("FAIL hs_latency: got %0d want 257", lat); end
        vectors++;
        if (bf !== 1) begin miscompares++; $display("FAIL hs_busy_first: got %0d want 1", bf); end
        vectors++;
        if (bc !== 257) begin miscompares++; $display("FAIL hs_busy_cycles: got %0d want 257", bc); end
        @(negedge clk);
        vectors++;
        if (res_valid_a !== 1'b1 || req_busy_a !== 1'b1) begin
            miscompares++;
            $display("FAIL hs_hold_done: got valid=%b busy=%b want 1 1", res_valid_a, req_busy_a);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (req_ready_a !== 1'b1 || res_valid_a !== 1'b0 || req_busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL hs_return_idle: got ready=%b valid=%b busy=%b want 1 0 0", req_ready_a, res_valid_a, req_busy_a);
        end
        vectors++;
        if (rnd_out_a !== ALT_WORD) begin miscompares++; $display("FAIL hs_word_hold: got %h want %h", rnd_out_a, ALT_WORD); end
        idle_busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_busy_a) idle_busy++;
        end
        vectors++;
        if (idle_busy !== 0) begin miscompares++; $display("FAIL hs_single_collection: got %0d busy cycles want 0", idle_busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bf, bc;
        collect(0, 1, 0, 400, 0, 0, 100, lat, bf, bc);
        #1;
        vectors++;
        if (req_ready_a !== 1'b1 || req_busy_a !== 1'b0 || res_valid_a !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got ready=%b busy=%b valid=%b want 1 0 0", req_ready_a, req_busy_a, res_valid_a);
        end
        vectors++;
        if (rnd_out_a !== 128'h0) begin miscompares++; $display("FAIL mid_reset_word: got %h want 0", rnd_out_a); end
        @(negedge clk);
        rstn = 1'b1;
        collect(0, 1, 0, 400, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 257) begin miscompares++; $display("FAIL mid_fresh_latency: got %0d want 257", lat); end
        vectors++;
        if (rnd_out_a !== ALT_WORD) begin miscompares++; $display("FAIL mid_fresh_word: got %h want %h", rnd_out_a, ALT_WORD); end
        release_result();
    endtask

    task automatic test_decimation();
        int lat, bf, bc;
        pulse_reset();
        collect(1, 3, 0, 200, 0, 0, 0, lat, bf, bc);
        vectors++;
        if (lat !== 49) begin miscompares++; $display("FAIL div3_latency: got %0d want 49", lat); end
        vectors++;
        if (rnd_out_b !== 8'hAA) begin miscompares++; $display("FAIL div3_word: got %h want aa", rnd_out_b); end
        vectors++;
        if (fail_b !== 1'b0) begin miscompares++; $display("FAIL div3_fail: got %b want 0", fail_b); end
        release_result();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alternating();
        test_discard();
        test_stuck();
        test_handshake();
        test_reset_mid();
        test_decimation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
